// File: rtl/sort4_pkg.sv
// sort4_pkg: shared state encodings and the compare-exchange pair schedule
// for sort4_ctrl. The schedule is a fixed four-entry bubble sort.
package sort4_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SORT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int SORT_STEPS = 6;

  // Lower index of the pair compared at a given step.
  function automatic logic [1:0] pair_i(input logic [2:0] step);
    case (step)
      3'd0:    pair_i = 2'd0;
      3'd1:    pair_i = 2'd1;
      3'd2:    pair_i = 2'd2;
      3'd3:    pair_i = 2'd0;
      3'd4:    pair_i = 2'd1;
      default: pair_i = 2'd0;
    endcase
  endfunction

  // Upper index of the pair compared at a given step.
  function automatic logic [1:0] pair_j(input logic [2:0] step);
    case (step)
      3'd0:    pair_j = 2'd1;
      3'd1:    pair_j = 2'd2;
      3'd2:    pair_j = 2'd3;
      3'd3:    pair_j = 2'd1;
      3'd4:    pair_j = 2'd2;
      default: pair_j = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/sort4_cmp_swap.sv
// cmp_swap: combinational compare-exchange. lo is the value that belongs in
// the lower array index, hi the one for the upper index.
// Optional macro SORT4_DESCEND_EN flips the order to descending.
module cmp_swap #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic swap;

`ifdef SORT4_DESCEND_EN
  assign swap = (x < y);
`else
  assign swap = (x > y);
`endif

  // Equal operands never swap, which keeps the sort stable.
  always_comb begin
    lo = swap ? y : x;
    hi = swap ? x : y;
  end

endmodule

// File: rtl/sort4_ctrl.sv
// sort4_ctrl: collects four bytes, sorts them through one shared
// compare-exchange over six fixed steps, and presents the result under a
// valid/ready handshake.
// Optional macro SORT4_DESCEND_EN (honoured inside cmp_swap) selects
// descending order.
module sort4_ctrl
  import sort4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] ra,
  output logic [W-1:0] rb,
  output logic [W-1:0] rc,
  output logic [W-1:0] rd,
  output logic         busy
);

  state_t                state, state_nx;
  logic [1:0]            idx;
  logic [2:0]            step;
  logic [3:0][W-1:0]     data, data_nx;
  logic                  armed;
  logic [1:0]            pi, pj;
  logic [W-1:0]          cmp_lo, cmp_hi;
  logic                  last_step;

  // armed holds in_ready low while rst is asserted without a path from rst.
  assign in_ready  = (state == S_LOAD) && armed;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_SORT);

  assign pi        = pair_i(step);
  assign pj        = pair_j(step);
  assign last_step = (step == 3'(SORT_STEPS - 1));

  cmp_swap #(.W(W)) u_cmp (
    .x  (data[pi]),
    .y  (data[pj]),
    .lo (cmp_lo),
    .hi (cmp_hi)
  );

  // Post-exchange array for the current step.
  always_comb begin
    data_nx     = data;
    data_nx[pi] = cmp_lo;
    data_nx[pj] = cmp_hi;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:  if (in_valid && in_ready && idx == 2'd3) state_nx = S_SORT;
      S_SORT:  if (last_step) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_LOAD;
      default: state_nx = S_LOAD;
    endcase
  end

  // State, counters, data array and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
      armed <= 1'b0;
      idx   <= 2'd0;
      step  <= 3'd0;
      data  <= '0;
      ra    <= '0;
      rb    <= '0;
      rc    <= '0;
      rd    <= '0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      case (state)
        S_LOAD: begin
          if (in_valid && in_ready) begin
            data[idx] <= data_in;
            idx       <= idx + 2'd1;
            if (idx == 2'd3) step <= 3'd0;
          end
        end
        S_SORT: begin
          data <= data_nx;
          if (last_step) begin
            step <= 3'd0;
            ra   <= data_nx[0];
            rb   <= data_nx[1];
            rc   <= data_nx[2];
            rd   <= data_nx[3];
          end else begin
            step <= step + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sort4_ctrl.md
# sort4_ctrl

Sequenced four-entry 8-bit sorter built around one shared compare-exchange unit. It collects four bytes over a valid/ready input handshake and runs a fixed six-step bubble-sort schedule through that single comparator. The sorted group is presented on four registered outputs under a valid/ready output handshake. The block sits between a byte producer, such as a switch/keypad capture stage, and a display or downstream consumer.

## Interface
Parameters:
- W, 8, data width of each entry.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a byte on data_in.
- in_ready  output  1  block accepts a byte this cycle.
- data_in  input  W  input byte.
- out_valid  output  1  ra..rd hold a completed sorted group.
- out_ready  input  1  consumer takes the group.
- ra, rb, rc, rd  output  W each  sorted result; ra is smallest, rd largest (default order).
- busy  output  1  high while in the SORT state.

The block uses one clock, `clk`. Reset `rst` is synchronous and active-high.

## Operation
The block has three states: LOAD, SORT and DONE. Reset enters LOAD.

- **LOAD**
  - in_ready=1.
  - Each in_valid&&in_ready edge writes data_in to data[idx] and increments idx (2 bits).
  - The edge accepting idx==3 sets idx=0, step=0 and goes to SORT.
- **SORT**
  - in_ready=0, busy=1.
  - Each edge performs one compare-exchange on the pair selected by step, then increments step.
  - Step schedule 0..5 uses pairs (0,1), (1,2), (2,3), (0,1), (1,2), (0,1).
  - For each pair (i,j): if data[i] > data[j], swap them. Equal values are not swapped, so the sort is stable.
  - The step-5 edge also loads {ra,rb,rc,rd} from the post-swap array and goes to DONE.
  - The schedule is always six steps; there is no early exit.
- **DONE**
  - out_valid=1; ra..rd are held stable.
  - The out_valid&&out_ready edge goes to LOAD.
  - ra..rd keep their value until the next SORT→DONE edge.

Arithmetic is an unsigned W-bit magnitude compare only. No value is modified other than by the exchange.

Outputs in_ready, out_valid and busy decode from the registered state. No input-to-output combinational path exists.

Reset values:
- state=LOAD, idx=0, step=0, data[*]=0, ra=rb=rc=rd=0, out_valid=0, busy=0.
- in_ready=0 while rst is high, 1 on the first cycle after rst is released.

Boundary conditions:
- in_valid while not in LOAD is ignored; no data is lost internally, because in_ready=0 makes the producer hold.
- out_ready while not in DONE is ignored.
- rst asserted in any state discards partial input and any in-progress sort, and clears outputs on that edge.
- idx wraps 3→0 only through the LOAD→SORT transition.

## Timing
- Edge E0 accepts the 4th byte. Edges E1..E6 execute steps 0..5. out_valid=1 in the cycle after E6.
- Latency from the 4th accept to out_valid is 6 cycles.
- With out_ready held high, DONE lasts 1 cycle and in_ready returns in the cycle after E7.
- Minimum period per group is 11 cycles: 4 load, 6 sort, 1 done.
- The compare-exchange is combinational within one cycle. Its result is written to data[] on the same edge.

## Configuration
- Macro: `SORT4_DESCEND_EN`.
- Defined: the exchange condition becomes data[i] < data[j]. ra is then the largest and rd the smallest. The schedule and timing are unchanged.
- Undefined: ascending order, as described above.

## Structure
- Shared package `sort4_pkg` holds:
  - state encodings (LOAD=2'd0, SORT=2'd1, DONE=2'd2);
  - SORT_STEPS=6;
  - the pair-schedule constants (step→i, step→j).
- One sub-module, `cmp_swap`: a combinational compare-exchange with inputs x, y (W) and outputs lo, hi. It honours `SORT4_DESCEND_EN`.
- `sort4_ctrl` owns the FSM, idx/step counters, the data[] registers, the operand muxing into `cmp_swap` and the write-back.

## Test plan
- **Reset:** hold rst 3 cycles mid-SORT → next cycle state LOAD, ra..rd=0, out_valid=0, in_ready=1 after release.
- **Basic sort:** feed 8'h37, 8'h05, 8'hC2, 8'h10 with out_ready=1 → out_valid exactly 6 cycles after the 4th accept; ra..rd = 05, 10, 37, C2; in_ready is back on the following cycle.
- **Reverse input and duplicates:**
  - FF, 80, 80, 00 → 00, 80, 80, FF.
  - All-equal 5A ×4 → 5A ×4.
- **Output backpressure:** out_ready=0 for 10 cycles after out_valid → ra..rd stable, in_ready=0, and in_valid pulses are ignored; raising out_ready returns to LOAD after one edge.
- **Input gaps:** in_valid toggled 1-0-1-0 → only 4 accepted bytes are stored and the order is preserved.
- **`SORT4_DESCEND_EN` build:** 37, 05, C2, 10 → ra..rd = C2, 37, 10, 05 with identical latency.
